// File: rtl/orn_gate_filt.sv
// orn_gate_filt: registered N-input reduction gate (OR/AND/XOR/NOR) with a
// per-input inversion mask and a consecutive-sample qualification filter.
// Optional feature macro: ORN_GATE_FILT_STICKY_EN
//   defined     -> O_RISE pulse and STICKY flag logic present.
//   not defined -> O_RISE and STICKY tied low, CLR_STICKY ignored.
module orn_gate_filt #(
   parameter int             N        = 4,
   parameter logic [N-1:0]   INV_MASK = {N{1'b1}},
   parameter int             FILTER   = 3
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         CE,
   input  logic [1:0]   MODE,
   input  logic [N-1:0] I,
   output logic         O,
   output logic         O_RISE,
   output logic         STICKY,
   input  logic         CLR_STICKY
);

   // FILTER of 0 and 1 both mean "toggle on the first differing sample".
   localparam int FLT   = (FILTER < 1) ? 1 : FILTER;
   localparam int CNT_W = ($clog2(FILTER + 1) < 1) ? 1 : $clog2(FILTER + 1);
   localparam int CW1   = CNT_W + 1;

   localparam logic [1:0] MODE_OR  = 2'b00;
   localparam logic [1:0] MODE_AND = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;
   localparam logic [1:0] MODE_NOR = 2'b11;

   // Count value at which the pending raw value is committed to O.
   localparam logic [CNT_W:0] CNT_LAST = CW1'(FLT);

   logic [N-1:0]     ireg;
   logic [1:0]       mreg;
   logic             raw;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W:0]   cnt_inc;
   logic             o_nxt;

   // Input stage: capture masked inputs and function select when enabled.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples
      // pre-edge values regardless of block ordering.
      if (!RST_N) begin
         ireg <= '0;
         mreg <= MODE_OR;
      end else if (CE) begin
         ireg <= I ^ INV_MASK;
         mreg <= MODE;
      end
   end

   // Raw reduction, driven only from registered inputs.
   always_comb begin
      // NOTE: default assignment first so no path leaves raw unassigned
      // (an unassigned path would infer a latch).
      raw = 1'b0;
      case (mreg)
         MODE_OR:  raw = |ireg;
         MODE_AND: raw = &ireg;
         MODE_XOR: raw = ^ireg;
         MODE_NOR: raw = ~|ireg;
         default:  raw = 1'b0;
      endcase
   end

   assign cnt_inc = {1'b0, cnt} + CW1'(1);

   // Qualification: commit raw to O after FLT consecutive differing samples;
   // any agreeing sample discards the accumulated count.
   always_comb begin
      o_nxt   = O;
      cnt_nxt = '0;
      if (raw != O) begin
         if (cnt_inc == CNT_LAST) begin
            o_nxt = raw;
         end else begin
            cnt_nxt = cnt_inc[CNT_W-1:0];
         end
      end
   end

   // Filter state and qualified output register.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt <= '0;
         O   <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         O   <= o_nxt;
      end
   end

`ifdef ORN_GATE_FILT_STICKY_EN
   // Rising-edge pulse and sticky flag; setting beats clearing.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         O_RISE <= 1'b0;
         STICKY <= 1'b0;
      end else begin
         O_RISE <= o_nxt & ~O;
         if (O_RISE) begin
            STICKY <= 1'b1;
         end else if (CLR_STICKY) begin
            STICKY <= 1'b0;
         end
      end
   end
`else
   assign O_RISE = 1'b0;
   assign STICKY = 1'b0;
   logic unused_clr_sticky;
   assign unused_clr_sticky = CLR_STICKY;
`endif

endmodule

// File: tb/tb_orn_gate_filt.sv
// Self-checking bench for orn_gate_filt: three configurations driven from a
// shared stimulus, compared every cycle against a window-based model, plus
// directed checks with hand-computed expectations.
module tb_orn_gate_filt;

`ifdef ORN_GATE_FILT_STICKY_EN
   localparam bit STK_EN = 1'b1;
`else
   localparam bit STK_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        CE;
   logic [1:0]  MODE;
   logic [31:0] stim;
   logic        CLR_STICKY;

   logic o_a, r_a, s_a;
   logic o_b, r_b, s_b;
   logic o_c, r_c, s_c;

   always #5 CLK = ~CLK;

   // A: default configuration (4 inputs, all inverted, FILTER=3).
   orn_gate_filt u_a (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .MODE(MODE), .I(stim[3:0]),
      .O(o_a), .O_RISE(r_a), .STICKY(s_a), .CLR_STICKY(CLR_STICKY));

   // B: 5 inputs, mixed inversion, FILTER=2.
   orn_gate_filt #(.N(5), .INV_MASK(5'b10010), .FILTER(2)) u_b (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .MODE(MODE), .I(stim[4:0]),
      .O(o_b), .O_RISE(r_b), .STICKY(s_b), .CLR_STICKY(CLR_STICKY));

   // C: 4 inputs, no inversion, no filtering.
   orn_gate_filt #(.N(4), .INV_MASK(4'h0), .FILTER(0)) u_c (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .MODE(MODE), .I(stim[3:0]),
      .O(o_c), .O_RISE(r_c), .STICKY(s_c), .CLR_STICKY(CLR_STICKY));

   logic d_o[3], d_r[3], d_s[3];
   assign d_o[0] = o_a; assign d_r[0] = r_a; assign d_s[0] = s_a;
   assign d_o[1] = o_b; assign d_r[1] = r_b; assign d_s[1] = s_b;
   assign d_o[2] = o_c; assign d_r[2] = r_c; assign d_s[2] = s_c;

   int          cfg_n[3]   = '{4, 5, 4};
   logic [31:0] cfg_msk[3] = '{32'hF, 32'h12, 32'h0};
   int          cfg_flt[3] = '{3, 2, 1};

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_ireg[3];
   logic [1:0]  m_mreg[3];
   bit          m_o[3], m_rise[3], m_stk[3];
   int          m_last[3];
   bit          hist[3][8192];
   int          t = 0;
   bit          m_ok = 1'b0;

   function automatic bit raw_of(input logic [31:0] v, input logic [1:0] m,
                                 input int n);
      logic [31:0] ones;
      ones = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      case (m)
         2'd0:    return v != 0;
         2'd1:    return v == ones;
         2'd2:    return ($countones(v) % 2) == 1;
         default: return v == 0;
      endcase
   endfunction

   // O toggles when the last FLT samples, all taken after the most recent
   // toggle or reset, disagree with O.
   always @(posedge CLK) begin
      bit r, flip, prev_rise;
      t++;
      for (int d = 0; d < 3; d++) begin
         r = raw_of(m_ireg[d], m_mreg[d], cfg_n[d]);
         hist[d][t] = r;
         if (!RST_N) begin
            m_ireg[d] = '0; m_mreg[d] = 2'b00;
            m_o[d] = 0; m_rise[d] = 0; m_stk[d] = 0;
            m_last[d] = t;
         end else begin
            prev_rise = m_rise[d];
            flip = 1'b1;
            for (int k = 0; k < cfg_flt[d]; k++)
               if ((t - k) <= m_last[d] || hist[d][t - k] == m_o[d]) flip = 1'b0;
            m_rise[d] = 1'b0;
            if (flip) begin
               m_o[d] = ~m_o[d];
               m_last[d] = t;
               m_rise[d] = STK_EN & m_o[d];
            end
            if (STK_EN) begin
               if (prev_rise) m_stk[d] = 1'b1;
               else if (CLR_STICKY) m_stk[d] = 1'b0;
            end
            if (CE) begin
               m_ireg[d] = (stim ^ cfg_msk[d]) &
                           ((cfg_n[d] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << cfg_n[d]) - 32'h1));
               m_mreg[d] = MODE;
            end
         end
      end
      if (!RST_N) m_ok = 1'b1;
   end

   // Compare process: every cycle once the model has seen a reset.
   always @(negedge CLK) begin
      if (m_ok) begin
         for (int d = 0; d < 3; d++) begin
            check($sformatf("cmp_o[%0d]", d), d_o[d], m_o[d]);
            check($sformatf("cmp_rise[%0d]", d), d_r[d], m_rise[d]);
            check($sformatf("cmp_sticky[%0d]", d), d_s[d], m_stk[d]);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      RST_N = 1'b0; CE = 1'b1; MODE = 2'b00; stim = 32'hF; CLR_STICKY = 1'b0;

      // Reset, then release with I=F (A raw=0) and raise via I=7.
      step(1);
      check("rst_o", o_a, 1'b0);
      check("rst_sticky", s_a, 1'b0);
      step(1);
      check("rst_o2", o_a, 1'b0);
      RST_N = 1'b1;
      step(6);
      check("post_rst_o", o_a, 1'b0);
      stim = 32'h7; CLR_STICKY = 1'b1;
      step(3);
      check("lat_o_3", o_a, 1'b0);
      step(1);
      check("lat_o_4", o_a, 1'b1);
      check("lat_model_o_4", m_o[0], 1'b1);
      check("lat_rise", r_a, STK_EN);
      step(1);
      check("rise_drop", r_a, 1'b0);
      check("sticky_set_wins", s_a, STK_EN);
      step(1);
      check("sticky_clr", s_a, 1'b0);
      CLR_STICKY = 1'b0;

      // Glitch rejection: 2-sample pulse ignored, 3-sample pulse passes.
      stim = 32'hF; step(2); stim = 32'h7;
      step(6);
      check("glitch2_o", o_a, 1'b1);
      stim = 32'hF; step(3); stim = 32'h7;
      step(1);
      check("glitch3_o", o_a, 1'b0);
      check("glitch3_model_o", m_o[0], 1'b0);
      step(6);

      // Function select on C (no inversion, no filtering): I=0110.
      stim = 32'h6; MODE = 2'b00;
      step(4);
      check("mode_or", o_c, 1'b1);
      MODE = 2'b01;
      step(1);
      check("mode_and_lat1", o_c, 1'b1);
      step(1);
      check("mode_and", o_c, 1'b0);
      check("mode_and_model", m_o[2], 1'b0);
      MODE = 2'b10; step(2);
      check("mode_xor", o_c, 1'b0);
      MODE = 2'b11; step(2);
      check("mode_nor", o_c, 1'b0);
      MODE = 2'b00; step(1);
      check("mode_or_lat1", o_c, 1'b0);
      step(1);
      check("mode_or_again", o_c, 1'b1);

      // CE hold on A.
      stim = 32'h0; step(8);
      check("ce_pre", o_a, 1'b1);
      CE = 1'b0; stim = 32'hF;
      step(10);
      check("ce_hold", o_a, 1'b1);
      CE = 1'b1;
      step(3);
      check("ce_lat3", o_a, 1'b1);
      step(1);
      check("ce_lat4", o_a, 1'b0);

      // Reset mid-count clears the counter.
      stim = 32'h0; step(3);
      RST_N = 1'b0; step(1);
      check("midrst_o", o_a, 1'b0);
      RST_N = 1'b1;
      step(3);
      check("midrst_fresh", o_a, 1'b0);
      step(1);
      check("midrst_rise", o_a, 1'b1);

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(9) < 3) stim = $urandom;
         CE = ($urandom_range(3) != 0);
         if ($urandom_range(9) == 0) MODE = 2'($urandom_range(3));
         CLR_STICKY = ($urandom_range(4) == 0);
         RST_N = ($urandom_range(99) != 0);
         step(1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
